// File: rtl/game_frame_sequencer_pkg.sv
// Shared definitions for the game frame sequencer: state encoding, default
// key codes and the channel-id width helper.
package game_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACK   = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_CAP   = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_DRAW  = 3'd5;
  localparam logic [2:0] S_END   = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  localparam logic [7:0] KEY_INC_DEFAULT    = 8'h75;
  localparam logic [7:0] KEY_DEC_DEFAULT    = 8'h72;
  localparam logic [7:0] SWITCH_KEY_DEFAULT = 8'h76;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/game_frame_sequencer_if.sv
// Bus bundle between the sequencer and the memory, GPU, keyboard and
// interrupt controllers.
interface game_frame_sequencer_if #(
  parameter int N_IRQ = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
);
  localparam int IW = game_pkg::id_width(N_IRQ);

  logic          MEM_ENABLE;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_DATA_R;
  logic [DW-1:0] MEM_DATA_W;
  logic          GPU_READY;
  logic          GPU_DRAW;
  logic [7:0]    KBD_KEY;
  logic [N_IRQ-1:0] INT_IRQ;
  logic          INT_IACK;
  logic          INT_IEND;
  logic [IW-1:0] INT_ID;

  modport master (
    output MEM_ENABLE, MEM_WRITE, MEM_ADDR, MEM_DATA_W, GPU_DRAW,
           INT_IACK, INT_IEND, INT_ID,
    input  MEM_DATA_R, GPU_READY, KBD_KEY, INT_IRQ
  );

  modport slave (
    input  MEM_ENABLE, MEM_WRITE, MEM_ADDR, MEM_DATA_W, GPU_DRAW,
           INT_IACK, INT_IEND, INT_ID,
    output MEM_DATA_R, GPU_READY, KBD_KEY, INT_IRQ
  );

endinterface

// File: rtl/game_frame_sequencer_irq_priority_encoder.sv
// Lowest-index-wins priority encoder for the interrupt request lines.
module irq_priority_encoder #(
  parameter int N_IRQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_IRQ-1:0] irq,
  output logic             valid,
  output logic [IW-1:0]    index
);

  always_comb begin
    valid = |irq;
    index = '0;
    // Scan downwards so the lowest set bit is the last one to win.
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (irq[i-1]) index = IW'(i - 1);
    end
  end

endmodule

// File: rtl/game_frame_sequencer.sv
// Interrupt-driven frame engine: per accepted IRQ it acks, samples the key,
// read-modify-writes the channel's object block, draws, then ends the IRQ.
module game_frame_sequencer
  import game_pkg::*;
#(
  parameter int             N_IRQ       = 2,
  parameter int             AW          = 16,
  parameter int             DW          = 16,
  parameter int             NUM_OBJ     = 4,
  parameter logic [AW-1:0]  BASE_ADDR   = '0,
  parameter int             STEP        = 1,
  parameter logic [7:0]     KEY_INC     = KEY_INC_DEFAULT,
  parameter logic [7:0]     KEY_DEC     = KEY_DEC_DEFAULT,
  parameter logic [7:0]     SWITCH_KEY  = SWITCH_KEY_DEFAULT,
  parameter int             GPU_TIMEOUT = 1023
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic ENABLE,
  output logic SWITCH_REQUEST,
  output logic FATAL_ERROR,
  game_frame_sequencer_if.master bus
);

  localparam int IW = id_width(N_IRQ);
  localparam int CW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int TW = $clog2(GPU_TIMEOUT + 1);

  logic [2:0]    state, nxt;
  logic [IW-1:0] id;
  logic [7:0]    key_buf;
  logic [DW-1:0] data_buf;
  logic [CW-1:0] obj_cnt;
  logic [TW-1:0] tcnt;

  logic          irq_valid;
  logic [IW-1:0] irq_idx;
  logic          last_obj;
  logic [AW-1:0] obj_addr;
  logic [DW-1:0] wdata;

  irq_priority_encoder #(.N_IRQ(N_IRQ), .IW(IW)) u_prio (
    .irq   (bus.INT_IRQ),
    .valid (irq_valid),
    .index (irq_idx)
  );

  assign last_obj = (obj_cnt == CW'(NUM_OBJ - 1));
  assign obj_addr = BASE_ADDR + AW'(id) * AW'(NUM_OBJ) + AW'(obj_cnt);

  always_comb begin
    if (key_buf == KEY_INC)      wdata = data_buf + DW'(STEP);
    else if (key_buf == KEY_DEC) wdata = data_buf - DW'(STEP);
    else                         wdata = data_buf;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (irq_valid) nxt = S_ACK;
      S_ACK:   nxt = S_RD;
      S_RD:    nxt = S_CAP;
      S_CAP:   nxt = S_WR;
      S_WR:    nxt = last_obj ? S_DRAW : S_RD;
      S_DRAW: begin
        if (bus.GPU_READY)                   nxt = S_END;
        else if (tcnt == TW'(GPU_TIMEOUT - 1)) nxt = S_ERROR;
      end
      S_END:   nxt = S_IDLE;
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_IDLE;
    endcase
    // ENABLE overrides everything except the terminal error state.
    if (!ENABLE && state != S_ERROR) nxt = S_IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      id       <= '0;
      key_buf  <= '0;
      data_buf <= '0;
      obj_cnt  <= '0;
      tcnt     <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: if (ENABLE && irq_valid) id <= irq_idx;
        S_ACK: begin
          key_buf <= bus.KBD_KEY;
          obj_cnt <= '0;
        end
        S_CAP:  data_buf <= bus.MEM_DATA_R;
        S_WR: begin
          if (last_obj) tcnt    <= '0;
          else          obj_cnt <= obj_cnt + CW'(1);
        end
        S_DRAW: if (!bus.GPU_READY) tcnt <= tcnt + TW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.MEM_ENABLE = (state == S_RD) || (state == S_WR);
    bus.MEM_WRITE  = (state == S_WR);
    bus.MEM_ADDR   = bus.MEM_ENABLE ? obj_addr : '0;
    bus.MEM_DATA_W = (state == S_WR) ? wdata : '0;
    bus.GPU_DRAW   = (state == S_DRAW) && bus.GPU_READY;
    bus.INT_IACK   = (state == S_ACK);
    bus.INT_IEND   = (state == S_END);
    bus.INT_ID     = (state != S_IDLE && state != S_ERROR) ? id : '0;
    SWITCH_REQUEST = (state == S_END) && (key_buf == SWITCH_KEY);
    FATAL_ERROR    = (state == S_ERROR);
  end

endmodule

// File: tb/tb_game_frame_sequencer.sv
// Directed bench for game_frame_sequencer with a behavioural memory model.
module tb_game_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic sw_req;
  logic fatal;

  always #5 clk = ~clk;

  game_frame_sequencer_if #(.N_IRQ(2), .AW(16), .DW(16)) bus ();

  game_frame_sequencer #(
    .N_IRQ(2), .AW(16), .DW(16), .NUM_OBJ(4), .BASE_ADDR(16'h0000), .STEP(1),
    .KEY_INC(8'h75), .KEY_DEC(8'h72), .SWITCH_KEY(8'h76), .GPU_TIMEOUT(1023)
  ) dut (
    .CLK            (clk),
    .RESET_N        (rst_n),
    .ENABLE         (enable),
    .SWITCH_REQUEST (sw_req),
    .FATAL_ERROR    (fatal),
    .bus            (bus)
  );

  // Memory model: registered read data, write on strobe, bench preload port.
  logic [15:0]      mem [0:255];
  logic             ld_en;
  logic [7:0]       ld_base;
  logic [3:0][15:0] ld_words;

  always @(posedge clk) begin
    if (ld_en) begin
      for (int k = 0; k < 4; k++) mem[ld_base + 8'(k)] <= ld_words[k];
    end else if (bus.MEM_ENABLE && bus.MEM_WRITE) begin
      mem[bus.MEM_ADDR[7:0]] <= bus.MEM_DATA_W;
    end
    if (bus.MEM_ENABLE && !bus.MEM_WRITE) bus.MEM_DATA_R <= mem[bus.MEM_ADDR[7:0]];
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic preload(input logic [7:0] base, input logic [3:0][15:0] w);
    ld_base  = base;
    ld_words = w;
    ld_en    = 1'b1;
    @(posedge clk); #1;
    ld_en    = 1'b0;
  endtask

  function automatic logic [63:0] block(input int base);
    return {mem[base+3], mem[base+2], mem[base+1], mem[base]};
  endfunction

  task automatic do_frame(input logic [1:0] irq, input logic [7:0] key, input bit clr,
                          output int iack_c, output int iend_c, output int draw_c,
                          output int draws, output logic id_end, output logic sw_end,
                          output logic sw_other);
    int cyc = 0;
    iack_c = -1; iend_c = -1; draw_c = -1; draws = 0;
    id_end = 1'b0; sw_end = 1'b0; sw_other = 1'b0;
    bus.INT_IRQ = irq;
    bus.KBD_KEY = key;
    while (iend_c < 0 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (bus.INT_IACK && iack_c < 0) begin
        iack_c = cyc;
        if (clr) bus.INT_IRQ = '0;
      end
      if (bus.GPU_DRAW) begin draws++; draw_c = cyc; end
      if (bus.INT_IEND) begin
        iend_c = cyc;
        id_end = bus.INT_ID;
        sw_end = sw_req;
      end else if (sw_req) sw_other = 1'b1;
    end
  endtask

  typedef struct {
    logic [1:0]       irq;
    logic [7:0]       key;
    int               base;
    logic [3:0][15:0] init;   // {w3, w2, w1, w0}
    logic [3:0][15:0] expv;
    logic             id;
    logic             sw;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int   iack_c, iend_c, draw_c, draws, cyc, reads, last_wr, fatal_c;
    logic id_end, sw_end, sw_other, found, bad;

    vecs[0] = '{2'b01, 8'h75, 0, {16'd8, 16'd7, 16'd6, 16'd5},
                {16'd9, 16'd8, 16'd7, 16'd6}, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 8'h72, 4, {16'hFFFF, 16'd2, 16'd1, 16'd0},
                {16'hFFFE, 16'd1, 16'd0, 16'hFFFF}, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 8'h76, 0, {16'd40, 16'd30, 16'd20, 16'd10},
                {16'd40, 16'd30, 16'd20, 16'd10}, 1'b0, 1'b1};
    vecs[3] = '{2'b10, 8'h00, 4, {16'h4444, 16'h3333, 16'h2222, 16'h1234},
                {16'h4444, 16'h3333, 16'h2222, 16'h1234}, 1'b1, 1'b0};
    vecs[4] = '{2'b11, 8'h75, 0, {16'h8000, 16'h7FFF, 16'd0, 16'hFFFF},
                {16'h8001, 16'h8000, 16'd1, 16'd0}, 1'b0, 1'b0};

    rst_n = 1'b0; enable = 1'b1; ld_en = 1'b0; ld_base = '0; ld_words = '0;
    bus.GPU_READY = 1'b1; bus.INT_IRQ = '0; bus.KBD_KEY = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.MEM_ENABLE, bus.MEM_WRITE, bus.MEM_ADDR, bus.MEM_DATA_W,
                          bus.GPU_DRAW, bus.INT_IACK, bus.INT_IEND, bus.INT_ID, sw_req, fatal}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset while a write is on the bus.
    preload(8'd0, {16'd4, 16'd3, 16'd2, 16'd1});
    bus.INT_IRQ = 2'b01; bus.KBD_KEY = 8'h75; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.INT_IACK) bus.INT_IRQ = '0;
      if (bus.MEM_WRITE) found = 1'b1;
    end
    check("reach_wr", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.MEM_ENABLE, bus.MEM_WRITE, bus.MEM_ADDR, bus.MEM_DATA_W,
                                  bus.GPU_DRAW, bus.INT_IACK, bus.INT_IEND, bus.INT_ID, sw_req, fatal}, '0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {bus.MEM_ENABLE, bus.INT_IACK, bus.INT_ID}, '0);

    // Table-driven single frames.
    for (int v = 0; v < 5; v++) begin
      preload(8'(vecs[v].base), vecs[v].init);
      do_frame(vecs[v].irq, vecs[v].key, 1'b1, iack_c, iend_c, draw_c, draws, id_end, sw_end, sw_other);
      check($sformatf("v%0d_mem", v), block(vecs[v].base), vecs[v].expv);
      check($sformatf("v%0d_id", v), id_end, vecs[v].id);
      check($sformatf("v%0d_switch", v), {sw_end, sw_other}, {vecs[v].sw, 1'b0});
      check($sformatf("v%0d_iack_cycle", v), iack_c, 1);
      check($sformatf("v%0d_draw", v), {draws[7:0], draw_c[7:0]}, {8'd1, 8'd14});
      check($sformatf("v%0d_iend_cycle", v), iend_c, 15);
      @(posedge clk); #1;
      check($sformatf("v%0d_idle_after", v), {bus.MEM_ENABLE, bus.INT_IACK, bus.INT_IEND, bus.INT_ID}, '0);
    end

    // Simultaneous IRQs: channel 0 first, then channel 1 with wrap below zero.
    preload(8'd0, {16'd4, 16'd3, 16'd2, 16'd1});
    preload(8'd4, {16'd7, 16'd6, 16'd5, 16'd0});
    do_frame(2'b11, 8'h72, 1'b0, iack_c, iend_c, draw_c, draws, id_end, sw_end, sw_other);
    check("simul_first_id", id_end, 0);
    check("simul_first_mem", block(0), {16'd3, 16'd2, 16'd1, 16'd0});
    check("simul_ch1_untouched", block(4), {16'd7, 16'd6, 16'd5, 16'd0});
    bus.INT_IRQ = 2'b10;
    do_frame(2'b10, 8'h72, 1'b1, iack_c, iend_c, draw_c, draws, id_end, sw_end, sw_other);
    check("simul_second_id", id_end, 1);
    check("simul_second_mem", block(4), {16'd6, 16'd5, 16'd4, 16'hFFFF});
    @(posedge clk); #1;

    // ENABLE dropped during the second read.
    preload(8'd0, {16'd400, 16'd300, 16'd200, 16'd100});
    bus.INT_IRQ = 2'b01; bus.KBD_KEY = 8'h75; reads = 0;
    for (int i = 0; i < 30 && reads < 2; i++) begin
      @(posedge clk); #1;
      if (bus.MEM_ENABLE && !bus.MEM_WRITE) reads++;
    end
    check("abort_reached_rd2", reads, 2);
    enable = 1'b0; bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.MEM_ENABLE || bus.INT_IEND || bus.INT_IACK || bus.GPU_DRAW) bad = 1'b1;
    end
    check("abort_quiet", bad, 0);
    check("abort_mem", block(0), {16'd400, 16'd300, 16'd200, 16'd101});
    bus.INT_IRQ = '0; enable = 1'b1;
    @(posedge clk); #1;

    // GPU never ready: timeout into sticky error.
    bus.GPU_READY = 1'b0; bus.INT_IRQ = 2'b01; bus.KBD_KEY = 8'h00;
    last_wr = -1; fatal_c = -1; cyc = 0;
    while (fatal_c < 0 && cyc < 1200) begin
      @(posedge clk); #1; cyc++;
      if (bus.INT_IACK) bus.INT_IRQ = '0;
      if (bus.MEM_WRITE) last_wr = cyc;
      if (fatal) fatal_c = cyc;
    end
    check("timeout_gap", fatal_c - last_wr, 1024);
    bus.GPU_READY = 1'b1; bus.INT_IRQ = 2'b01; bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enable = i[0];
      @(posedge clk); #1;
      if (!fatal || bus.MEM_ENABLE || bus.INT_IACK || bus.INT_IEND || bus.GPU_DRAW || bus.INT_ID != 0)
        bad = 1'b1;
    end
    check("error_sticky", bad, 0);
    rst_n = 1'b0; #1;
    check("error_cleared_by_reset", fatal, 0);
    bus.INT_IRQ = '0; enable = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
